axi_spi_if: RTL and testbench
=============================

Name: axi_spi_if

Overview:
AXI4-Lite slave that exposes a small word-addressed register file and drives a single-master SPI port with four active-low slave selects. Software programs the control and transfer-control registers, then writes a TX byte to start an 8-bit full-duplex transfer and reads the received byte back. It sits on the system peripheral bus between the CPU interconnect and off-chip SPI devices.

Parameters:
NUM_SS, 4, number of slave-select outputs (fixed at 4 for the port list).
DATA_W, 8, SPI transfer width in bits.

Ports:
clk_i  in  1  system clock, all logic on rising edge
reset_i  in  1  synchronous active-high reset
awvalid_i  in  1  write address valid
awready_o  out  1  write address accepted
awaddr_i  in  28  write word address (register index)
awprot_i  in  1  ignored
wvalid_i  in  1  write data valid
wready_o  out  1  write data accepted
wdata_i  in  32  write data
wstrb_i  in  4  ignored; full-word writes
bvalid_o  out  1  write response valid
bready_i  in  1  write response ready
bresp_o  out  2  00 OKAY, 10 SLVERR
arvalid_i  in  1  read address valid
arready_o  out  1  read address accepted
araddr_i  in  28  read word address
arprot_i  in  3  ignored
rvalid_o  out  1  read data valid
rready_i  in  1  read data ready
rdata_o  out  32  read data
rresp_o  out  2  00 OKAY, 10 SLVERR
spi_ssel_o  out  4  active-low slave selects
spi_sck_o  out  1  SPI clock
spi_mosi_o  out  1  master out
spi_miso_i  in  1  master in

Behaviour:
- Reset (reset_i=1 at clk edge): all registers 0; awready_o=wready_o=arready_o=bvalid_o=rvalid_o=0; bresp_o=rresp_o=00; rdata_o=0; spi_ssel_o=4'hF; spi_sck_o=CPOL(=0); spi_mosi_o=0; any transfer aborted.
- Register map (word index): 0 CONTROL RW: [1] enable, [2] CPOL, [3] CPHA, [15:8] DIV. 1 TRANS_CTRL RW: [1:0] slave index. 2 STATUS RO: [0] busy, [1] rx_valid. 3 TXDATA WO: [7:0] byte; write starts transfer. 4 RXDATA RO: [7:0] last received byte; read clears rx_valid. Unused bits read 0.
- Write channel: when awvalid_i && wvalid_i && !bvalid_o, pulse awready_o and wready_o together for one cycle, perform write in that cycle; bvalid_o asserted next cycle, held until bready_i. Only one write outstanding.
- Read channel: when arvalid_i && !rvalid_o, pulse arready_o one cycle; next cycle rvalid_o=1 with rdata_o/rresp_o held until rready_i.
- SLVERR: write to index 2 or 4; write to 3 while busy or enable=0; any access to index >4. SLVERR writes change no state; SLVERR reads return 0.
- SPI engine: on accepted TXDATA write, busy=1, ssel[slave index] driven low the next cycle, others high. SCK half period = DIV+1 clk cycles; DIV=0 gives clk/2. 8 bits, MSB first. CPHA=0: MOSI valid before first edge, sample MISO on leading edge, shift on trailing edge; CPHA=1: shift on leading, sample on trailing. After 16 half periods: SCK returns to CPOL, ssel all high, RXDATA updated, rx_valid=1, busy=0.
- Clearing enable mid-transfer aborts at next clk: ssel high, SCK idle, busy=0, RXDATA unchanged.
- CONTROL/TRANS_CTRL writes during busy are accepted but take effect only at the next transfer.
- Simultaneous read and write handled independently; read of STATUS sees pre-write value.

Optional Feature:
SPI_LOOPBACK_EN: when defined, CONTROL[4] is a RW loopback bit; when set, the receive shifter samples spi_mosi_o internally instead of spi_miso_i (pins still toggle). When undefined, CONTROL[4] reads 0 and MISO is always used.

Decomposition:
Package axi_spi_pkg: register index constants, bresp/rresp codes, CONTROL/STATUS field bit positions. One sub-module spi_shift_engine (clock divider, 8-bit shifter, ssel, done strobe); the AXI register file stays in axi_spi_if.

Test Plan:
- Reset then read index 0..4 -> all return 0, rresp 00; spi_ssel_o=4'hF.
- Write 0x602 to 0, 0x2 to 1 -> bresp 00; readback 0x602, 0x2.
- Write 0x73 to 3 with MISO=1 -> ssel=4'b1011, MOSI shifts 0,1,1,1,0,0,1,1 MSB first, SCK half period 7 clk cycles; done: RXDATA=0xFF, STATUS=0x2.
- Write 0x73 to 4 -> bresp 10, no state change; write to 3 while busy -> bresp 10, transfer unaffected.
- Hold bready_i=0 after write -> bvalid_o stays 1, second write not accepted until bready_i=1.
- Clear enable mid-transfer -> ssel 4'hF, SCK=0, busy=0 next cycle.

Source files
------------

// File: rtl/axi_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_spi_pkg
//  Description : Register indices, response codes, CONTROL/STATUS field
//                positions and engine state encoding for axi_spi_if.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_spi_pkg;

    localparam int c_addr_w = 28;

    localparam logic [c_addr_w-1:0] c_idx_control = 28'd0;
    localparam logic [c_addr_w-1:0] c_idx_trans   = 28'd1;
    localparam logic [c_addr_w-1:0] c_idx_status  = 28'd2;
    localparam logic [c_addr_w-1:0] c_idx_txdata  = 28'd3;
    localparam logic [c_addr_w-1:0] c_idx_rxdata  = 28'd4;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    localparam int c_ctrl_en      = 1;
    localparam int c_ctrl_cpol    = 2;
    localparam int c_ctrl_cpha    = 3;
    localparam int c_ctrl_lb      = 4;
    localparam int c_ctrl_div_lsb = 8;
    localparam int c_ctrl_div_msb = 15;

    localparam int c_stat_busy = 0;
    localparam int c_stat_rxv  = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_spi_if_engine.sv
`default_nettype none
// ============================================================================
//  Module      : spi_shift_engine
//  Description : SPI master shifter: clock divider, MSB-first shift/sample,
//                slave select and a one-cycle done strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_engine
    import axi_spi_pkg::*;
#(
    parameter int NUM_SS = 4,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic [DATA_W-1:0]         i_tx_byte,
    input  logic [7:0]                i_div,
    input  logic                      i_cpol,
    input  logic                      i_cpha,
    input  logic                      i_loopback,
    input  logic [$clog2(NUM_SS)-1:0] i_ss_idx,
    input  logic                      i_miso,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [DATA_W-1:0]         o_rx_byte,
    output logic                      o_sck,
    output logic                      o_mosi,
    output logic [NUM_SS-1:0]         o_ssel
);

    localparam int                    c_half_w    = $clog2(2*DATA_W);
    localparam logic [c_half_w-1:0]   c_last_half = c_half_w'(2*DATA_W-1);
    localparam int                    c_ss_w      = $clog2(NUM_SS);

    spi_state_e          state_q, state_d;
    logic [7:0]          div_q, div_d, div_cnt_q, div_cnt_d;
    logic [c_half_w-1:0] half_q, half_d;
    logic                phase_q, phase_d;
    logic                cpol_q, cpol_d, cpha_q, cpha_d, lb_q, lb_d;
    logic [c_ss_w-1:0]   ss_q, ss_d;
    logic [DATA_W-1:0]   tx_q, tx_d, rx_q, rx_d;
    logic                w_leading, w_rx_bit;

    assign w_rx_bit  = lb_q ? tx_q[DATA_W-1] : i_miso;
    assign w_leading = ~half_q[0];

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        div_cnt_d = div_cnt_q;
        half_d    = half_q;
        phase_d   = phase_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lb_d      = lb_q;
        ss_d      = ss_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        o_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    // Configuration is frozen here so mid-transfer writes wait
                    state_d   = ST_XFER;
                    div_d     = i_div;
                    div_cnt_d = '0;
                    half_d    = '0;
                    phase_d   = 1'b0;
                    cpol_d    = i_cpol;
                    cpha_d    = i_cpha;
                    lb_d      = i_loopback;
                    ss_d      = i_ss_idx;
                    tx_d      = i_tx_byte;
                    rx_d      = '0;
                end
            end
            ST_XFER: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                    phase_d = 1'b0;
                end else if (div_cnt_q == div_q) begin
                    div_cnt_d = '0;
                    phase_d   = ~phase_q;
                    half_d    = half_q + c_half_w'(1);
                    if (w_leading != cpha_q)
                        rx_d = {rx_q[DATA_W-2:0], w_rx_bit};
                    // With CPHA=1 the first leading edge presents the MSB already loaded
                    if ((!w_leading && !cpha_q) || (w_leading && cpha_q && half_q != '0))
                        tx_d = {tx_q[DATA_W-2:0], 1'b0};
                    if (half_q == c_last_half) begin
                        state_d = ST_IDLE;
                        phase_d = 1'b0;
                        o_done  = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            div_cnt_q <= '0;
            half_q    <= '0;
            phase_q   <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lb_q      <= 1'b0;
            ss_q      <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            half_q    <= half_d;
            phase_q   <= phase_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lb_q      <= lb_d;
            ss_q      <= ss_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
        end
    end

    assign o_busy    = (state_q == ST_XFER);
    assign o_rx_byte = rx_d;
    assign o_sck     = o_busy ? (cpol_q ^ phase_q) : i_cpol;
    assign o_mosi    = o_busy ? tx_q[DATA_W-1] : 1'b0;
    assign o_ssel    = o_busy ? ~(NUM_SS'(1) << ss_q) : '1;

endmodule
`default_nettype wire

// File: rtl/axi_spi_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_spi_if
//  Description : AXI4-Lite register file driving a single-master SPI port.
//                Optional macro SPI_LOOPBACK_EN adds CONTROL[4] loopback.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_spi_if
    import axi_spi_pkg::*;
#(
    parameter int NUM_SS = 4,
    parameter int DATA_W = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                awvalid_i,
    output logic                awready_o,
    input  logic [c_addr_w-1:0] awaddr_i,
    input  logic                awprot_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    input  logic [31:0]         wdata_i,
    input  logic [3:0]          wstrb_i,
    output logic                bvalid_o,
    input  logic                bready_i,
    output logic [1:0]          bresp_o,
    input  logic                arvalid_i,
    output logic                arready_o,
    input  logic [c_addr_w-1:0] araddr_i,
    input  logic [2:0]          arprot_i,
    output logic                rvalid_o,
    input  logic                rready_i,
    output logic [31:0]         rdata_o,
    output logic [1:0]          rresp_o,
    output logic [NUM_SS-1:0]   spi_ssel_o,
    output logic                spi_sck_o,
    output logic                spi_mosi_o,
    input  logic                spi_miso_i
);

    localparam int c_ss_w = $clog2(NUM_SS);

    logic              awready_q, awready_d, arready_q, arready_d;
    logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              en_q, en_d, cpol_q, cpol_d, cpha_q, cpha_d;
    logic [7:0]        div_q, div_d;
    logic [c_ss_w-1:0] ss_q, ss_d;
    logic              rxv_q, rxv_d;
    logic [DATA_W-1:0] rxdata_q, rxdata_d, w_rx_byte;
    logic              w_wr_hs, w_rd_hs, w_wr_err, w_wr_ok, w_start, w_busy, w_done, w_lb;
    logic              w_rd_err;
    logic [31:0]       w_rd_word;
    logic              w_unused;

    assign w_unused = ^{awprot_i, arprot_i, wstrb_i, wdata_i[31:16]};

    assign w_wr_hs = awready_q && awvalid_i && wvalid_i;
    assign w_rd_hs = arready_q && arvalid_i;
    assign w_wr_ok = w_wr_hs && !w_wr_err;
    assign w_start = w_wr_ok && (awaddr_i == c_idx_txdata);

    always_comb begin
        w_wr_err = 1'b0;
        if (awaddr_i > c_idx_rxdata || awaddr_i == c_idx_status || awaddr_i == c_idx_rxdata)
            w_wr_err = 1'b1;
        else if (awaddr_i == c_idx_txdata && (w_busy || !en_q))
            w_wr_err = 1'b1;
    end

    always_comb begin
        w_rd_word = '0;
        w_rd_err  = (araddr_i > c_idx_rxdata);
        case (araddr_i)
            c_idx_control: begin
                w_rd_word[c_ctrl_en]                      = en_q;
                w_rd_word[c_ctrl_cpol]                    = cpol_q;
                w_rd_word[c_ctrl_cpha]                    = cpha_q;
                w_rd_word[c_ctrl_lb]                      = w_lb;
                w_rd_word[c_ctrl_div_msb:c_ctrl_div_lsb]  = div_q;
            end
            c_idx_trans:  w_rd_word[c_ss_w-1:0] = ss_q;
            c_idx_status: begin
                w_rd_word[c_stat_busy] = w_busy;
                w_rd_word[c_stat_rxv]  = rxv_q;
            end
            c_idx_rxdata: w_rd_word[DATA_W-1:0] = rxdata_q;
            default:      w_rd_word = '0;
        endcase
    end

    always_comb begin
        awready_d = awvalid_i && wvalid_i && !bvalid_q && !awready_q;
        arready_d = arvalid_i && !rvalid_q && !arready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        en_d      = en_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        div_d     = div_q;
        ss_d      = ss_q;
        rxv_d     = rxv_q;
        rxdata_d  = rxdata_q;

        if (w_wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = w_wr_err ? c_resp_slverr : c_resp_okay;
        end else if (bvalid_q && bready_i) begin
            bvalid_d = 1'b0;
        end

        if (w_rd_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = w_rd_err ? c_resp_slverr : c_resp_okay;
            rdata_d  = w_rd_err ? 32'd0 : w_rd_word;
        end else if (rvalid_q && rready_i) begin
            rvalid_d = 1'b0;
        end

        if (w_wr_ok && awaddr_i == c_idx_control) begin
            en_d   = wdata_i[c_ctrl_en];
            cpol_d = wdata_i[c_ctrl_cpol];
            cpha_d = wdata_i[c_ctrl_cpha];
            div_d  = wdata_i[c_ctrl_div_msb:c_ctrl_div_lsb];
        end
        if (w_wr_ok && awaddr_i == c_idx_trans)
            ss_d = wdata_i[c_ss_w-1:0];

        if (w_rd_hs && araddr_i == c_idx_rxdata)
            rxv_d = 1'b0;
        // A completing transfer wins over a simultaneous RXDATA read
        if (w_done) begin
            rxv_d    = 1'b1;
            rxdata_d = w_rx_byte;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= c_resp_okay;
            rvalid_q  <= 1'b0;
            rresp_q   <= c_resp_okay;
            rdata_q   <= '0;
            en_q      <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            div_q     <= '0;
            ss_q      <= '0;
            rxv_q     <= 1'b0;
            rxdata_q  <= '0;
        end else begin
            awready_q <= awready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            en_q      <= en_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            div_q     <= div_d;
            ss_q      <= ss_d;
            rxv_q     <= rxv_d;
            rxdata_q  <= rxdata_d;
        end
    end

`ifdef SPI_LOOPBACK_EN
    logic lb_q, lb_d;
    always_comb begin
        lb_d = lb_q;
        if (w_wr_ok && awaddr_i == c_idx_control)
            lb_d = wdata_i[c_ctrl_lb];
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) lb_q <= 1'b0;
        else         lb_q <= lb_d;
    end
    assign w_lb = lb_q;
`else
    assign w_lb = 1'b0;
`endif

    // Abort takes effect on the same edge that clears enable
    spi_shift_engine #(.NUM_SS(NUM_SS), .DATA_W(DATA_W)) u_engine (
        .clk        (clk_i),
        .rst        (reset_i),
        .i_start    (w_start),
        .i_abort    (!en_d),
        .i_tx_byte  (wdata_i[DATA_W-1:0]),
        .i_div      (div_q),
        .i_cpol     (cpol_q),
        .i_cpha     (cpha_q),
        .i_loopback (w_lb),
        .i_ss_idx   (ss_q),
        .i_miso     (spi_miso_i),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_rx_byte  (w_rx_byte),
        .o_sck      (spi_sck_o),
        .o_mosi     (spi_mosi_o),
        .o_ssel     (spi_ssel_o)
    );

    assign awready_o = awready_q;
    assign wready_o  = awready_q;
    assign arready_o = arready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign rvalid_o  = rvalid_q;
    assign rresp_o   = rresp_q;
    assign rdata_o   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_spi_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_spi_if
//  Description : Directed self-checking bench for axi_spi_if.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_spi_if;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        awvalid_i, awready_o, awprot_i, wvalid_i, wready_o;
    logic [27:0] awaddr_i, araddr_i;
    logic [31:0] wdata_i, rdata_o;
    logic [3:0]  wstrb_i, spi_ssel_o;
    logic        bvalid_o, bready_i, arvalid_i, arready_o, rvalid_o, rready_i;
    logic [1:0]  bresp_o, rresp_o;
    logic [2:0]  arprot_i;
    logic        spi_sck_o, spi_mosi_o, spi_miso_i;

    int          n_chk = 0;
    int          n_err = 0;
    logic [3:0]  ssel_at_b;
    logic        sck_at_b;

    always #5 clk_i = ~clk_i;

    axi_spi_if dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i), .awprot_i(awprot_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o),
        .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i), .arprot_i(arprot_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
        .spi_ssel_o(spi_ssel_o), .spi_sck_o(spi_sck_o), .spi_mosi_o(spi_mosi_o),
        .spi_miso_i(spi_miso_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Tasks start and finish 1 time unit after a rising edge
    task automatic axi_write(input logic [27:0] a, input logic [31:0] d, output logic [1:0] resp);
        int t;
        awaddr_i = a; wdata_i = d; awvalid_i = 1'b1; wvalid_i = 1'b1;
        t = 0;
        while (!awready_o && t < 50) begin step(); t++; end
        check("wr_awready", 32'(awready_o & wready_o), 32'd1);
        step();
        awvalid_i = 1'b0; wvalid_i = 1'b0;
        t = 0;
        while (!bvalid_o && t < 50) begin step(); t++; end
        check("wr_bvalid", 32'(bvalid_o), 32'd1);
        ssel_at_b = spi_ssel_o;
        sck_at_b  = spi_sck_o;
        resp = bresp_o;
        bready_i = 1'b1;
        step();
        bready_i = 1'b0;
    endtask

    task automatic axi_read(input logic [27:0] a, output logic [31:0] d, output logic [1:0] resp);
        int t;
        araddr_i = a; arvalid_i = 1'b1;
        t = 0;
        while (!arready_o && t < 50) begin step(); t++; end
        check("rd_arready", 32'(arready_o), 32'd1);
        step();
        arvalid_i = 1'b0;
        t = 0;
        while (!rvalid_o && t < 50) begin step(); t++; end
        check("rd_rvalid", 32'(rvalid_o), 32'd1);
        d = rdata_o; resp = rresp_o;
        rready_i = 1'b1;
        step();
        rready_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (spi_ssel_o != 4'hF && t < 400) begin step(); t++; end
        check(tag, 32'(spi_ssel_o), 32'hF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr, br;
        logic [7:0]  tx;
        int          t;

        reset_i = 1'b1;
        awvalid_i = 0; awaddr_i = '0; awprot_i = 0; wvalid_i = 0; wdata_i = '0; wstrb_i = 4'hF;
        bready_i = 0; arvalid_i = 0; araddr_i = '0; arprot_i = '0; rready_i = 0; spi_miso_i = 0;
        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        check("rst_ssel", 32'(spi_ssel_o), 32'hF);
        check("rst_sck", 32'(spi_sck_o), 32'd0);
        check("rst_mosi", 32'(spi_mosi_o), 32'd0);
        check("rst_bvalid", 32'(bvalid_o), 32'd0);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            axi_read(28'(i), rd, rr);
            check($sformatf("rst_rdata%0d", i), rd, 32'd0);
            check($sformatf("rst_rresp%0d", i), 32'(rr), 32'd0);
        end

        // Enable, DIV=6, CPOL=CPHA=0; slave 2
        axi_write(28'd0, 32'h602, br); check("ctrl_bresp", 32'(br), 32'd0);
        axi_write(28'd1, 32'h2, br);   check("trans_bresp", 32'(br), 32'd0);
        axi_read(28'd0, rd, rr);       check("ctrl_rd", rd, 32'h602);
        axi_read(28'd1, rd, rr);       check("trans_rd", rd, 32'h2);

        // Response back-pressure: second write must wait for bready
        awaddr_i = 28'd1; wdata_i = 32'h1; awvalid_i = 1; wvalid_i = 1;
        t = 0;
        while (!bvalid_o && t < 50) begin step(); t++; end
        check("hold_bvalid", 32'(bvalid_o), 32'd1);
        check("hold_bresp", 32'(bresp_o), 32'd0);
        wdata_i = 32'h3;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("hold_bvalid_c%0d", i), 32'(bvalid_o), 32'd1);
            check($sformatf("hold_awready_c%0d", i), 32'(awready_o), 32'd0);
        end
        axi_read(28'd1, rd, rr);       check("hold_first_wr", rd, 32'h1);
        bready_i = 1; step(); bready_i = 0;
        t = 0;
        while (!awready_o && t < 50) begin step(); t++; end
        check("hold_2nd_awready", 32'(awready_o), 32'd1);
        step();
        awvalid_i = 0; wvalid_i = 0;
        t = 0;
        while (!bvalid_o && t < 50) begin step(); t++; end
        bready_i = 1; step(); bready_i = 0;
        axi_read(28'd1, rd, rr);       check("hold_second_wr", rd, 32'h3);
        axi_write(28'd1, 32'h2, br);

        // Transfer 1: 0x73 to slave 2, MISO held high
        spi_miso_i = 1'b1;
        tx = 8'h73;
        axi_write(28'd3, 32'h73, br);  check("tx1_bresp", 32'(br), 32'd0);
        check("tx1_ssel", 32'(spi_ssel_o), 32'hB);
        for (int b = 7; b >= 0; b--) begin
            t = 0;
            while (!spi_sck_o && t < 100) begin step(); t++; end
            check($sformatf("tx1_mosi_b%0d", b), 32'(spi_mosi_o), 32'(tx[b]));
            t = 0;
            while (spi_sck_o && t < 100) begin step(); t++; end
            if (b == 7) check("tx1_half_period", 32'(t), 32'd7);
        end
        wait_idle("tx1_end_ssel");
        check("tx1_end_sck", 32'(spi_sck_o), 32'd0);
        axi_read(28'd2, rd, rr);       check("tx1_status", rd, 32'h2);
        axi_read(28'd4, rd, rr);       check("tx1_rxdata", rd, 32'hFF);
        axi_read(28'd2, rd, rr);       check("tx1_status_clr", rd, 32'h0);

        // Error responses while idle
        axi_write(28'd4, 32'h73, br);  check("wr_rx_bresp", 32'(br), 32'd2);
        axi_read(28'd4, rd, rr);       check("wr_rx_nochange", rd, 32'hFF);
        axi_write(28'd2, 32'h3, br);   check("wr_status_bresp", 32'(br), 32'd2);
        axi_read(28'd5, rd, rr);       check("rd_idx5_data", rd, 32'd0);
        check("rd_idx5_rresp", 32'(rr), 32'd2);

        // Transfer 2: MISO low; TXDATA write while busy is rejected
        spi_miso_i = 1'b0;
        axi_write(28'd3, 32'h5A, br);  check("tx2_bresp", 32'(br), 32'd0);
        axi_write(28'd3, 32'h11, br);  check("tx2_busy_bresp", 32'(br), 32'd2);
        axi_read(28'd2, rd, rr);       check("tx2_status_busy", rd, 32'h1);
        check("tx2_ssel", 32'(spi_ssel_o), 32'hB);
        wait_idle("tx2_end_ssel");
        axi_read(28'd2, rd, rr);       check("tx2_status", rd, 32'h2);
        axi_read(28'd4, rd, rr);       check("tx2_rxdata", rd, 32'h00);

        // Transfer 3: aborted by clearing enable
        spi_miso_i = 1'b1;
        axi_write(28'd3, 32'h33, br);  check("tx3_bresp", 32'(br), 32'd0);
        repeat (20) step();
        check("tx3_ssel_active", 32'(spi_ssel_o), 32'hB);
        axi_write(28'd0, 32'h600, br); check("abort_bresp", 32'(br), 32'd0);
        check("abort_ssel", 32'(ssel_at_b), 32'hF);
        check("abort_sck", 32'(sck_at_b), 32'd0);
        axi_read(28'd2, rd, rr);       check("abort_status", rd, 32'h0);
        axi_read(28'd4, rd, rr);       check("abort_rxdata", rd, 32'h00);
        axi_write(28'd3, 32'h33, br);  check("tx_disabled_bresp", 32'(br), 32'd2);
        check("tx_disabled_ssel", 32'(spi_ssel_o), 32'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
